// File: rtl/mdu_exec_unit.sv
// Multi-cycle multiply/divide execute unit returning tagged HI/LO or GPR results.
// Optional CLZ/CLO support is compiled in when MDU_CLZ_EN is defined.

`ifndef FUNCT_BUS
`define FUNCT_BUS     7
`define FUNCT_MULT    7'h18
`define FUNCT_MULTU   7'h19
`define FUNCT_DIV     7'h1A
`define FUNCT_DIVU    7'h1B
`define FUNCT2_MADD   7'h40
`define FUNCT2_MADDU  7'h41
`define FUNCT2_MUL    7'h42
`define FUNCT2_MSUB   7'h44
`define FUNCT2_MSUBU  7'h45
`define FUNCT2_CLZ    7'h60
`define FUNCT2_CLO    7'h61
`endif

module mdu_exec_unit #(
   parameter int MUL_LATENCY = 3,
   parameter int TAG_WIDTH   = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [`FUNCT_BUS-1:0] in_funct,
   input  logic [TAG_WIDTH-1:0]  in_tag,
   input  logic [31:0]           in_a,
   input  logic [31:0]           in_b,
   input  logic [31:0]           in_hi,
   input  logic [31:0]           in_lo,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [TAG_WIDTH-1:0]  out_tag,
   output logic [31:0]           out_hi,
   output logic [31:0]           out_lo,
   output logic                  out_hilo_we,
   output logic                  out_gpr_we
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DIV, S_DONE} state_t;

   state_t                 state_r, state_s;
   logic [5:0]             cnt_r;
   logic [`FUNCT_BUS-1:0]  funct_r;
   logic [TAG_WIDTH-1:0]   tag_r;
   logic [31:0]            a_r, b_r, hi_r, lo_r;
   logic [31:0]            rem_r, quo_r, dvsr_r;
   logic                   accept_s, load_s, in_div_s, in_mul_s;
   logic [32:0]            shifted_s;
   logic [33:0]            diff_s;
   logic [31:0]            rem_s, quo_s;
   logic [63:0]            sprod_s, uprod_s, acc_s;
   logic [31:0]            res_hi_s, res_lo_s;
   logic                   res_hilo_we_s, res_gpr_we_s;
   logic                   sdiv_s;

   function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
      return (sgn && v[31]) ? (32'd0 - v) : v;
   endfunction

`ifdef MDU_CLZ_EN
   function automatic logic [5:0] clz32(input logic [31:0] v);
      logic [5:0] n;
      logic       found;
      n     = 6'd0;
      found = 1'b0;
      for (int i = 31; i >= 0; i--) begin
         if (!found && !v[i]) n = n + 6'd1;
         else                 found = 1'b1;
      end
      return n;
   endfunction
`endif

   assign accept_s = (state_r == S_IDLE) && in_valid && !flush;
   assign in_div_s = (in_funct == `FUNCT_DIV) || (in_funct == `FUNCT_DIVU);
   assign in_mul_s = (in_funct == `FUNCT_MULT)   || (in_funct == `FUNCT_MULTU) ||
                     (in_funct == `FUNCT2_MADD)  || (in_funct == `FUNCT2_MADDU) ||
                     (in_funct == `FUNCT2_MSUB)  || (in_funct == `FUNCT2_MSUBU) ||
                     (in_funct == `FUNCT2_MUL);
   assign load_s   = !flush && (((state_r == S_EXEC) && (cnt_r == 6'd0)) ||
                                ((state_r == S_DIV) && (cnt_r == 6'd32)));

   // Next-state selection; flush always returns to IDLE
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (in_valid) state_s = in_div_s ? S_DIV : S_EXEC;
            else          state_s = S_IDLE;
         end
         S_EXEC:  state_s = (cnt_r == 6'd0)  ? S_DONE : S_EXEC;
         S_DIV:   state_s = (cnt_r == 6'd32) ? S_DONE : S_DIV;
         S_DONE:  state_s = out_ready ? S_IDLE : S_DONE;
         default: state_s = S_IDLE;
      endcase
      if (flush) state_s = S_IDLE;
      else       state_s = state_s;
   end

   // State register with registered handshake flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= S_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         state_r   <= state_s;
         in_ready  <= (state_s == S_IDLE);
         out_valid <= (state_s == S_DONE);
      end
   end

   // One restoring step: shift in the next dividend bit, subtract if it fits
   always_comb begin
      shifted_s = {rem_r, quo_r[31]};
      diff_s    = {1'b0, shifted_s} - {2'b00, dvsr_r};
      if (!diff_s[33]) begin
         rem_s = diff_s[31:0];
         quo_s = {quo_r[30:0], 1'b1};
      end else begin
         rem_s = shifted_s[31:0];
         quo_s = {quo_r[30:0], 1'b0};
      end
   end

   // Operand capture, latency counter and divider iteration
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r   <= 6'd0;
         funct_r <= '0;
         tag_r   <= '0;
         a_r     <= 32'd0;
         b_r     <= 32'd0;
         hi_r    <= 32'd0;
         lo_r    <= 32'd0;
         rem_r   <= 32'd0;
         quo_r   <= 32'd0;
         dvsr_r  <= 32'd0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (accept_s) begin
                  funct_r <= in_funct;
                  tag_r   <= in_tag;
                  a_r     <= in_a;
                  b_r     <= in_b;
                  hi_r    <= in_hi;
                  lo_r    <= in_lo;
                  rem_r   <= 32'd0;
                  quo_r   <= mag32(in_a, in_funct == `FUNCT_DIV);
                  dvsr_r  <= mag32(in_b, in_funct == `FUNCT_DIV);
                  cnt_r   <= in_mul_s ? 6'(MUL_LATENCY - 1) : 6'd0;
               end
            end
            S_EXEC: if (cnt_r != 6'd0) cnt_r <= cnt_r - 6'd1;
            S_DIV: begin
               if (cnt_r != 6'd32) begin
                  rem_r <= rem_s;
                  quo_r <= quo_s;
                  cnt_r <= cnt_r + 6'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign sprod_s = $signed({{32{a_r[31]}}, a_r}) * $signed({{32{b_r[31]}}, b_r});
   assign uprod_s = {32'd0, a_r} * {32'd0, b_r};
   assign acc_s   = {hi_r, lo_r};
   assign sdiv_s  = (funct_r == `FUNCT_DIV);

   // Final result; the divide branch doubles as the sign-fixup step
   always_comb begin
      res_hi_s      = 32'd0;
      res_lo_s      = 32'd0;
      res_hilo_we_s = 1'b0;
      res_gpr_we_s  = 1'b0;
      case (funct_r)
         `FUNCT_MULT:   begin {res_hi_s, res_lo_s} = sprod_s;         res_hilo_we_s = 1'b1; end
         `FUNCT_MULTU:  begin {res_hi_s, res_lo_s} = uprod_s;         res_hilo_we_s = 1'b1; end
         `FUNCT2_MADD:  begin {res_hi_s, res_lo_s} = acc_s + sprod_s; res_hilo_we_s = 1'b1; end
         `FUNCT2_MADDU: begin {res_hi_s, res_lo_s} = acc_s + uprod_s; res_hilo_we_s = 1'b1; end
         `FUNCT2_MSUB:  begin {res_hi_s, res_lo_s} = acc_s - sprod_s; res_hilo_we_s = 1'b1; end
         `FUNCT2_MSUBU: begin {res_hi_s, res_lo_s} = acc_s - uprod_s; res_hilo_we_s = 1'b1; end
         `FUNCT2_MUL:   begin res_lo_s = sprod_s[31:0];               res_gpr_we_s  = 1'b1; end
         `FUNCT_DIV, `FUNCT_DIVU: begin
            res_hilo_we_s = 1'b1;
            if (b_r == 32'd0) begin
               res_lo_s = 32'hFFFF_FFFF;
               res_hi_s = a_r;
            end else begin
               res_lo_s = (sdiv_s && (a_r[31] ^ b_r[31])) ? (32'd0 - quo_r) : quo_r;
               res_hi_s = (sdiv_s && a_r[31]) ? (32'd0 - rem_r) : rem_r;
            end
         end
`ifdef MDU_CLZ_EN
         `FUNCT2_CLZ: begin res_lo_s = {26'd0, clz32(a_r)};  res_gpr_we_s = 1'b1; end
         `FUNCT2_CLO: begin res_lo_s = {26'd0, clz32(~a_r)}; res_gpr_we_s = 1'b1; end
`endif
         default: ;
      endcase
   end

   // Result registers, held while waiting for the consumer
   always_ff @(posedge clk) begin
      if (rst) begin
         out_tag     <= '0;
         out_hi      <= 32'd0;
         out_lo      <= 32'd0;
         out_hilo_we <= 1'b0;
         out_gpr_we  <= 1'b0;
      end else if (load_s) begin
         out_tag     <= tag_r;
         out_hi      <= res_hi_s;
         out_lo      <= res_lo_s;
         out_hilo_we <= res_hilo_we_s;
         out_gpr_we  <= res_gpr_we_s;
      end
   end

endmodule
